// File: rtl/vector_pkg.sv
// vector_pkg: shared fixed-point and pixel types for the ray marcher and its
// downstream shading stage.
//   fixed_t    : signed Q16.16 distance
//   FRAC_BITS  : fractional bits of fixed_t
//   MAX_DIST_Q : miss threshold (100.0), shared so marcher and shader agree
//   rgb_t      : 24-bit pixel {r, g, b}
//   pix_t      : pixel plus stream tags, as carried by the output slice
package vector_pkg;

  localparam int unsigned FRAC_BITS = 16;

  typedef logic signed [31:0] fixed_t;

  localparam logic [31:0] MAX_DIST_Q = 32'h0064_0000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t rgb;
    logic user;
    logic last;
  } pix_t;

  localparam int unsigned PIX_W = $bits(pix_t);

endpackage

// File: rtl/stream_skid.sv
// stream_skid: generic 2-entry valid/ready register slice.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : upstream handshake (in_ready is a flop output)
//   in_data            : upstream payload, WIDTH bits
//   out_valid/out_ready: downstream handshake
//   out_data           : downstream payload, held stable while stalled
module stream_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;

  // Ready only reflects the spare entry, so it never sees out_ready directly.
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && !skid_valid;

  // Main register feeds the output; the spare entry absorbs one beat on a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_data <= in_data;
        end
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/dist_shader.sv
// dist_shader: converts marched Q16.16 distances (raster order) into 24-bit
// RGB pixels on a valid/ready stream with start-of-frame and end-of-line tags.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : distance input handshake (in_ready registered)
//   in_distance[31:0]     : signed Q16.16 ray distance
//   out_valid/out_ready   : pixel output handshake
//   out_data[23:0]        : {R, G, B}
//   out_user              : first pixel of frame
//   out_last              : last pixel of line
// Build option: DIST_SHADER_TINT_EN selects depth tint (R=grey, G=grey>>1,
// B=255-grey) for hits instead of plain grey.
module dist_shader #(
  parameter int unsigned X_SIZE      = 640,
  parameter int unsigned Y_SIZE      = 480,
  parameter logic [31:0] MAX_DIST_Q  = vector_pkg::MAX_DIST_Q,
  parameter int unsigned SHADE_SHIFT = 15,
  parameter logic [23:0] BG_COLOUR   = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_distance,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data,
  output logic        out_user,
  output logic        out_last
);

  import vector_pkg::*;

  localparam int unsigned XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int unsigned YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  logic          in_fire;
  logic          out_fire;
  logic [1:0]    occ;
  logic [1:0]    occ_next;
  logic [1:0]    skid_cnt;

  fixed_t        dist_s;
  logic [31:0]   dist_u;
  logic [31:0]   shifted;
  logic [7:0]    grey;
  logic          hit;
  rgb_t          shade_c;

  logic          s1_valid;
  rgb_t          s1_rgb;
  logic          skid_in_ready;

  logic [XW-1:0] x, nx1, nx2, tx;
  logic [YW-1:0] y, ny1, ny2, ty;
  pix_t          skid_in;
  pix_t          skid_out;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Shade: clamp negatives, threshold for miss, saturate the full shifted value.
  always_comb begin
    dist_s  = fixed_t'(in_distance);
    dist_u  = (dist_s < 32'sd0) ? 32'd0 : in_distance;
    hit     = dist_u < MAX_DIST_Q;
    shifted = dist_u >> SHADE_SHIFT;
    grey    = (shifted > 32'd255) ? 8'd0 : 8'(32'd255 - shifted);
    shade_c = rgb_t'(BG_COLOUR);
    if (hit) begin
`ifdef DIST_SHADER_TINT_EN
      shade_c.r = grey;
      shade_c.g = {1'b0, grey[7:1]};
      shade_c.b = 8'hFF - grey;
`else
      shade_c.r = grey;
      shade_c.g = grey;
      shade_c.b = grey;
`endif
    end
  end

  // Stage 1 register; hands off to the output slice whenever it has room.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rgb   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_rgb   <= shade_c;
    end else if (skid_in_ready) begin
      s1_valid <= 1'b0;
    end
  end

  // Occupancy of stage 1 plus both slice entries. Ready is pre-computed for
  // the next cycle: at most 3 pixels held, and a third is only admitted while
  // the sink was draining, so a stall from empty stops intake after 2.
  always_comb begin
    occ_next = occ + 2'(in_fire) - 2'(out_fire);
    skid_cnt = occ - 2'(s1_valid);
  end

  // Pixels already in the slice sit at (x,y) and its successor, so the one
  // entering takes the position skid_cnt steps ahead of the output counters.
  always_comb begin
    nx1 = (x == X_LAST) ? '0 : x + XW'(1);
    ny1 = (x == X_LAST) ? ((y == Y_LAST) ? '0 : y + YW'(1)) : y;
    nx2 = (nx1 == X_LAST) ? '0 : nx1 + XW'(1);
    ny2 = (nx1 == X_LAST) ? ((ny1 == Y_LAST) ? '0 : ny1 + YW'(1)) : ny1;
    case (skid_cnt)
      2'd0:    begin tx = x;   ty = y;   end
      2'd1:    begin tx = nx1; ty = ny1; end
      default: begin tx = nx2; ty = ny2; end
    endcase
    skid_in.rgb  = s1_rgb;
    skid_in.user = (tx == '0) && (ty == '0);
    skid_in.last = (tx == X_LAST);
  end

  // Occupancy, registered ready, and output-side raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      in_ready <= 1'b1;
      x        <= '0;
      y        <= '0;
    end else begin
      occ      <= occ_next;
      in_ready <= (occ_next != 2'd3) && (!occ_next[1] || out_ready);
      if (out_fire) begin
        x <= nx1;
        y <= ny1;
      end
    end
  end

  stream_skid #(
    .WIDTH (PIX_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (skid_in_ready),
    .in_data   (skid_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_out)
  );

  assign out_data = skid_out.rgb;
  assign out_user = skid_out.user;
  assign out_last = skid_out.last;

endmodule
